// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: per-channel 2-stage synchronizer,
// 4-state debounce FSM with glitch abort, registered press/release strobes
// and an optional hold-to-repeat strobe.
//
// state      | meaning
// -----------+-----------------------------------------------------
// OFF        | committed released level, waiting for a high sample
// BEFORE_ON  | counting stable high samples before committing press
// ON         | committed pressed level, hold/repeat timing active
// BEFORE_OFF | counting stable low samples before committing release
module debounce_bank #(
   parameter int NUM_BTN      = 5,
   parameter int WAIT_COUNT   = 3,
   parameter bit REPEAT_EN    = 1'b1,
   parameter int HOLD_COUNT   = 1000,
   parameter int REPEAT_COUNT = 250
) (
   input  logic               CLOCK,
   input  logic               CPU_RESET,
   input  logic [NUM_BTN-1:0] BTN_IN,
   output logic [NUM_BTN-1:0] BTN_OUT,
   output logic [NUM_BTN-1:0] BTN_PRESS,
   output logic [NUM_BTN-1:0] BTN_RELEASE,
   output logic [NUM_BTN-1:0] BTN_REPEAT,
   output logic               ANY_ON
);

   typedef enum logic [1:0] {OFF, BEFORE_ON, ON, BEFORE_OFF} state_t;

   localparam int CNT_W    = $clog2(WAIT_COUNT) + 1;
   localparam int RPT_MAX  = (HOLD_COUNT > REPEAT_COUNT) ? HOLD_COUNT : REPEAT_COUNT;
   localparam int RPT_W    = $clog2(RPT_MAX) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WAIT_COUNT - 1);
   localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_COUNT - 1);
   localparam logic [RPT_W-1:0] REP_LAST  = RPT_W'(REPEAT_COUNT - 1);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      logic [1:0]       sync;
      logic             s;
      state_t           state, state_nxt;
      logic [CNT_W-1:0] cnt, cnt_nxt;
      logic             press_nxt, release_nxt;
      logic             out_r, press_r, release_r;

      assign s = sync[1];

      // Two-flop synchronizer for the asynchronous raw button.
      always_ff @(posedge CLOCK or posedge CPU_RESET) begin
         if (CPU_RESET) sync <= 2'b00;
         else           sync <= {sync[0], BTN_IN[i]};
      end

      // Debounce next-state, counter and strobe decode.
      always_comb begin
         state_nxt   = state;
         cnt_nxt     = cnt;
         press_nxt   = 1'b0;
         release_nxt = 1'b0;
         case (state)
            OFF: begin
               if (s) begin
                  state_nxt = BEFORE_ON;
                  cnt_nxt   = '0;
               end
            end
            BEFORE_ON: begin
               if (!s) begin
                  state_nxt = OFF;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nxt = ON;
                  press_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            ON: begin
               if (!s) begin
                  state_nxt = BEFORE_OFF;
                  cnt_nxt   = '0;
               end
            end
            BEFORE_OFF: begin
               if (s) begin
                  state_nxt = ON;
               end else if (cnt == CNT_LAST) begin
                  state_nxt   = OFF;
                  release_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_nxt = OFF;
               cnt_nxt   = '0;
            end
         endcase
      end

      // State, counter and registered level/strobe outputs.
      always_ff @(posedge CLOCK or posedge CPU_RESET) begin
         if (CPU_RESET) begin
            state     <= OFF;
            cnt       <= '0;
            out_r     <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
         end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            out_r     <= (state_nxt == ON) || (state_nxt == BEFORE_OFF);
            press_r   <= press_nxt;
            release_r <= release_nxt;
         end
      end

      if (REPEAT_EN) begin : g_rpt
         logic [RPT_W-1:0] hold_cnt;
         logic             rpt_phase;
         logic             rpt_r;
         logic             term;

         // First terminal is the initial hold, then the repeat period.
         assign term = rpt_phase ? (hold_cnt == REP_LAST) : (hold_cnt == HOLD_LAST);

         // Hold/repeat timer; only runs while committed ON and staying ON.
         always_ff @(posedge CLOCK or posedge CPU_RESET) begin
            if (CPU_RESET) begin
               hold_cnt  <= '0;
               rpt_phase <= 1'b0;
               rpt_r     <= 1'b0;
            end else if (state != ON) begin
               hold_cnt  <= '0;
               rpt_phase <= 1'b0;
               rpt_r     <= 1'b0;
            end else if (s && term) begin
               hold_cnt  <= '0;
               rpt_phase <= 1'b1;
               rpt_r     <= 1'b1;
            end else begin
               rpt_r <= 1'b0;
               if (!term) hold_cnt <= hold_cnt + RPT_W'(1);
            end
         end

         assign BTN_REPEAT[i] = rpt_r;
      end else begin : g_no_rpt
         assign BTN_REPEAT[i] = 1'b0;
      end

      assign BTN_OUT[i]     = out_r;
      assign BTN_PRESS[i]   = press_r;
      assign BTN_RELEASE[i] = release_r;
   end

   assign ANY_ON = |BTN_OUT;

endmodule
